spi_mstr_cfg: RTL and testbench
===============================

// Module: spi_mstr_cfg
// PURPOSE
//  Parametrised, mode-configurable SPI master; next generation of the team's fixed 16-bit mode-3 master.
//  Width, SCLK divider, porch delay and slave-select count are parameters; CPOL/CPHA are selectable per transfer.
//  Full-duplex: shifts cmd out on MOSI MSB-first while capturing MISO. Sits between the host FSM and off-chip SPI peripherals.
// PARAMETERS
//  DATA_W    16  bits per transfer, legal 2..32
//  SCLK_DIV  32  clk cycles per SCLK period, even, >=4
//  PORCH     4   clk cycles from SS_n fall to first SCLK edge, and from last SCLK edge to SS_n rise, >=2
//  NUM_SS    1   number of slave-select lines; SEL_W = max(1, $clog2(NUM_SS))
// PORTS
//  clk      in   1       system clock
//  rst_n    in   1       asynchronous active-low reset
//  wrt      in   1       start request; accepted only when busy==0
//  cmd      in   DATA_W  data to transmit, latched on accept
//  ss_sel   in   SEL_W   slave index, latched on accept
//  cpol     in   1       SCLK idle level, latched on accept
//  cpha     in   1       0: sample on leading edge; 1: sample on trailing edge. Latched on accept.
//  MISO     in   1       serial data from slave
//  SCLK     out  1       serial clock
//  MOSI     out  1       serial data to slave
//  SS_n     out  NUM_SS  active-low slave selects, one-hot-low during a transfer
//  busy     out  1       high from the cycle after accept until done
//  done     out  1       one-cycle pulse; rd_data valid the same cycle
//  rd_data  out  DATA_W  captured MISO word, held until the next done
// BEHAVIOUR
//  Reset (async): SCLK=1, latched cpol=1, SS_n=all 1, MOSI=0, busy=0, done=0, rd_data=0, FSM=IDLE.
//  All outputs are registered and glitch-free.
//  FSM states: IDLE -> FRONT -> XFER -> BACK -> IDLE.
//   IDLE: SCLK=latched cpol, SS_n all high.
//    On wrt: latch cmd into shift reg, latch ss_sel/cpol/cpha, go to FRONT.
//    wrt while busy is ignored; no queuing.
//   FRONT: SS_n[sel] low, SCLK at idle level, for PORCH cycles, then XFER.
//   XFER: SCLK toggles every SCLK_DIV/2 clk cycles; exactly 2*DATA_W edges; SCLK ends at idle level.
//    cpha=0: MOSI=cmd MSB from first FRONT cycle. Leading edge samples MISO into shift LSB; trailing edge shifts and drives next MSB.
//    cpha=1: leading edge shifts and drives MSB; trailing edge samples MISO.
//   BACK: SCLK idle for PORCH cycles, then IDLE.
//    On entering IDLE: SS_n all high, done=1, busy=0, rd_data<=shift reg.
//  Timing (wrt accepted at cycle 0):
//   SS_n falls at cycle 1.
//   First edge at cycle 1+PORCH.
//   Last edge at cycle 1+PORCH+(2*DATA_W-1)*SCLK_DIV/2.
//   done at last edge + PORCH.
//   Defaults: first edge 5, last edge 501, done 505.
//  Back-to-back: wrt on the done cycle is accepted, giving SS_n high for exactly one cycle between transfers.
//  ss_sel >= NUM_SS: no SS_n asserted; transfer still runs and completes with done.
//  cmd/ss_sel/cpol/cpha changes after accept have no effect on the current transfer.
//  rst_n low mid-transfer: outputs return to reset values immediately; no done; rd_data=0.
//  Illegal parameter values are rejected by an elaboration-time $error.
// TESTING
//  Defaults, cpol=1 cpha=1, cmd=16'hA5C3, MISO looped to MOSI -> rd_data=16'hA5C3 at cycle 505, 16 rising SCLK edges, busy 1..504.
//  cpol=0 cpha=0, slave model returns 16'h1234 -> SCLK idles 0, MOSI=1'b0 (bit15 of cmd 16'h0F0F) before first rising edge, rd_data=16'h1234.
//  wrt with cmd=16'hFFFF at cycle 200 of a transfer -> ignored; exactly one done at 505; MOSI stream matches the first cmd.
//  wrt asserted on the done cycle -> second transfer accepted, SS_n high exactly 1 cycle, second done at cycle 505+505.
//  NUM_SS=3: ss_sel=2 -> only SS_n[2] low. ss_sel=3 -> SS_n stays 3'b111 and done still at 505.
//  rst_n pulsed low at cycle 200 -> SCLK=1, SS_n all 1, busy=0 asynchronously, no done. DATA_W=8, SCLK_DIV=4, PORCH=2: new wrt completes, done at cycle 35.

Source files
------------

// File: rtl/spi_mstr_cfg.sv
// spi_mstr_cfg: parameterised, mode-configurable, full-duplex SPI master.
//
// Shifts cmd out on MOSI MSB-first while capturing MISO into the same shift register.
// CPOL/CPHA, slave index and data are latched when a request is accepted. All outputs
// are registered.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   wrt      in   start request, accepted only while idle (busy == 0)
//   cmd      in   DATA_W word to transmit
//   ss_sel   in   slave index; values >= NUM_SS select no slave
//   cpol     in   SCLK idle level
//   cpha     in   0: sample on leading edge, 1: sample on trailing edge
//   MISO     in   serial data from slave
//   SCLK     out  serial clock
//   MOSI     out  serial data to slave
//   SS_n     out  NUM_SS active-low slave selects
//   busy     out  transfer in progress
//   done     out  one-cycle completion pulse, rd_data valid in the same cycle
//   rd_data  out  captured MISO word, held until the next done

module spi_mstr_cfg #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SCLK_DIV = 32,
  parameter int unsigned PORCH    = 4,
  parameter int unsigned NUM_SS   = 1,
  localparam int unsigned SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt,
  input  logic [DATA_W-1:0] cmd,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              MISO,
  output logic              SCLK,
  output logic              MOSI,
  output logic [NUM_SS-1:0] SS_n,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data
);

  // Elaboration-time parameter checks
  if (DATA_W < 2 || DATA_W > 32) begin : g_bad_data_w
    $error("spi_mstr_cfg: DATA_W must be in 2..32");
  end
  if (SCLK_DIV < 4 || (SCLK_DIV % 2) != 0) begin : g_bad_sclk_div
    $error("spi_mstr_cfg: SCLK_DIV must be even and >= 4");
  end
  if (PORCH < 2) begin : g_bad_porch
    $error("spi_mstr_cfg: PORCH must be >= 2");
  end
  if (NUM_SS < 1) begin : g_bad_num_ss
    $error("spi_mstr_cfg: NUM_SS must be >= 1");
  end

  localparam int unsigned HALF    = SCLK_DIV / 2;
  localparam int unsigned CNT_MAX = (HALF > PORCH) ? HALF : PORCH;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned EDGES   = 2 * DATA_W;
  localparam int unsigned EDGE_W  = $clog2(EDGES + 1);

  localparam logic [CNT_W-1:0]  HalfLast  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0]  PorchLast = CNT_W'(PORCH - 1);
  localparam logic [EDGE_W-1:0] EdgeLast  = EDGE_W'(EDGES - 1);

  typedef enum logic [1:0] {StIdle, StFront, StXfer, StBack} state_e;

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   shift;
  logic                cpol_q;
  logic                cpha_q;
  logic [NUM_SS-1:0]   ss_dec;
  logic                sclk_edge;
  logic                leading;

  // Slave-select decode; an out-of-range index leaves every line high.
  always_comb begin
    ss_dec = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (ss_sel == SEL_W'(i)) ss_dec[i] = 1'b0;
    end
  end

  // The last FRONT cycle produces SCLK edge 0; in XFER an edge every HALF cycles.
  always_comb begin
    sclk_edge = ((state == StFront) && (cnt == PorchLast)) ||
                ((state == StXfer) && (cnt == HalfLast));
    leading   = ~edge_cnt[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      cnt      <= '0;
      edge_cnt <= '0;
      shift    <= '0;
      cpol_q   <= 1'b1;
      cpha_q   <= 1'b0;
      SCLK     <= 1'b1;
      MOSI     <= 1'b0;
      SS_n     <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_data  <= '0;
    end else begin
      done <= 1'b0;

      unique case (state)
        StIdle: begin
          SCLK <= cpol_q;
          if (wrt) begin
            state    <= StFront;
            cnt      <= '0;
            edge_cnt <= '0;
            shift    <= cmd;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            SCLK     <= cpol;
            SS_n     <= ss_dec;
            busy     <= 1'b1;
            // cpha=0 must present the MSB before the first (sampling) edge
            if (!cpha) MOSI <= cmd[DATA_W-1];
          end
        end
        StFront: begin
          if (cnt == PorchLast) begin
            state <= StXfer;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StXfer: begin
          if (cnt == HalfLast) begin
            cnt <= '0;
            if (edge_cnt == EdgeLast) state <= StBack;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        StBack: begin
          if (cnt == PorchLast) begin
            state   <= StIdle;
            cnt     <= '0;
            SS_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b1;
            rd_data <= shift;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= StIdle;
      endcase

      if (sclk_edge) begin
        SCLK     <= ~SCLK;
        edge_cnt <= edge_cnt + EDGE_W'(1);
        if (cpha_q) begin
          // Leading edge drives the next bit and frees the LSB for the trailing-edge sample.
          if (leading) begin
            MOSI  <= shift[DATA_W-1];
            shift <= {shift[DATA_W-2:0], 1'b0};
          end else begin
            shift[0] <= MISO;
          end
        end else begin
          // Leading edge samples MISO into the LSB as the sent MSB leaves; trailing edge
          // drives the next MSB, except after the final edge.
          if (leading) begin
            shift <= {shift[DATA_W-2:0], MISO};
          end else if (edge_cnt != EdgeLast) begin
            MOSI <= shift[DATA_W-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mstr_cfg.sv
// Directed self-checking bench for spi_mstr_cfg. Three instances: defaults, NUM_SS=3,
// and a small DATA_W=8 / SCLK_DIV=4 / PORCH=2 build. One shared stimulus set is steered
// to the selected instance and its outputs are observed through a mux.

module tb_spi_mstr_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int          dsel;
  logic        wrt;
  logic [15:0] cmd;
  logic        cpol;
  logic        cpha;
  logic [1:0]  ss_sel;
  logic        loop_en;
  logic [15:0] slave_sh;

  logic        d0_sclk, d0_mosi, d0_busy, d0_done, d0_miso;
  logic [0:0]  d0_ssn;
  logic [15:0] d0_rd;
  logic        d1_sclk, d1_mosi, d1_busy, d1_done, d1_miso;
  logic [2:0]  d1_ssn;
  logic [15:0] d1_rd;
  logic        d2_sclk, d2_mosi, d2_busy, d2_done, d2_miso;
  logic [0:0]  d2_ssn;
  logic [7:0]  d2_rd;

  assign d0_miso = loop_en ? d0_mosi : slave_sh[15];
  assign d1_miso = loop_en ? d1_mosi : slave_sh[15];
  assign d2_miso = loop_en ? d2_mosi : slave_sh[15];

  spi_mstr_cfg #(.DATA_W(16), .SCLK_DIV(32), .PORCH(4), .NUM_SS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .wrt(wrt && (dsel == 0)), .cmd(cmd), .ss_sel(1'b0),
    .cpol(cpol), .cpha(cpha), .MISO(d0_miso), .SCLK(d0_sclk), .MOSI(d0_mosi),
    .SS_n(d0_ssn), .busy(d0_busy), .done(d0_done), .rd_data(d0_rd)
  );

  spi_mstr_cfg #(.DATA_W(16), .SCLK_DIV(32), .PORCH(4), .NUM_SS(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .wrt(wrt && (dsel == 1)), .cmd(cmd), .ss_sel(ss_sel),
    .cpol(cpol), .cpha(cpha), .MISO(d1_miso), .SCLK(d1_sclk), .MOSI(d1_mosi),
    .SS_n(d1_ssn), .busy(d1_busy), .done(d1_done), .rd_data(d1_rd)
  );

  spi_mstr_cfg #(.DATA_W(8), .SCLK_DIV(4), .PORCH(2), .NUM_SS(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .wrt(wrt && (dsel == 2)), .cmd(cmd[7:0]), .ss_sel(1'b0),
    .cpol(cpol), .cpha(cpha), .MISO(d2_miso), .SCLK(d2_sclk), .MOSI(d2_mosi),
    .SS_n(d2_ssn), .busy(d2_busy), .done(d2_done), .rd_data(d2_rd)
  );

  // Observed outputs of the selected instance; absent select lines read as high.
  logic        m_sclk, m_mosi, m_busy, m_done;
  logic [2:0]  m_ssn;
  logic [15:0] m_rd;
  always_comb begin
    m_sclk = d0_sclk; m_mosi = d0_mosi; m_busy = d0_busy; m_done = d0_done;
    m_ssn  = {2'b11, d0_ssn}; m_rd = d0_rd;
    if (dsel == 1) begin
      m_sclk = d1_sclk; m_mosi = d1_mosi; m_busy = d1_busy; m_done = d1_done;
      m_ssn  = d1_ssn; m_rd = d1_rd;
    end else if (dsel == 2) begin
      m_sclk = d2_sclk; m_mosi = d2_mosi; m_busy = d2_busy; m_done = d2_done;
      m_ssn  = {2'b11, d2_ssn}; m_rd = {8'h00, d2_rd};
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-run observations (cycle numbers relative to the accept cycle 0)
  int          ss_fall, first_e, last_e, rises, busy_n, done_n, done1, done2, mid_hi;
  logic [15:0] rd1, rd2, mosi_w;
  logic [2:0]  ss_acc;
  logic        sclk_t1, mosi_t4;

  task automatic run(input int d, input logic [15:0] c, input logic pol, input logic pha,
                     input logic lp, input logic [15:0] slv, input logic [1:0] sel,
                     input int inj, input bit b2b, input logic [15:0] c2,
                     input int rst_at, input int limit);
    logic prev;
    ss_fall = -1; first_e = -1; last_e = -1; rises = 0; busy_n = 0; done_n = 0;
    done1 = -1; done2 = -1; mid_hi = 0; rd1 = '0; rd2 = '0; mosi_w = '0;
    ss_acc = 3'b111; sclk_t1 = 1'bx; mosi_t4 = 1'bx;
    @(negedge clk);
    dsel = d; cmd = c; cpol = pol; cpha = pha; loop_en = lp; slave_sh = slv;
    ss_sel = sel; wrt = 1'b1;
    prev = pol;
    for (int t = 1; t <= limit; t++) begin
      @(negedge clk);
      wrt = 1'b0;
      if (t == 1) sclk_t1 = m_sclk;
      if (t == 4) mosi_t4 = m_mosi;
      if (ss_fall < 0 && m_ssn != 3'b111) ss_fall = t;
      if (m_busy) begin
        busy_n++;
        ss_acc &= m_ssn;
      end
      if (m_sclk !== prev) begin
        if (first_e < 0) first_e = t;
        last_e = t;
        if (m_sclk) begin
          rises++;
          mosi_w = {mosi_w[14:0], m_mosi};
        end else begin
          slave_sh = {slave_sh[14:0], 1'b0};
        end
        prev = m_sclk;
      end
      if (m_done) begin
        done_n++;
        if (done_n == 1) begin
          done1 = t; rd1 = m_rd;
          if (b2b) begin
            cmd = c2; wrt = 1'b1;
          end
        end else begin
          done2 = t; rd2 = m_rd;
        end
      end
      if (ss_fall > 0 && done_n == 1 && m_ssn == 3'b111) mid_hi++;
      if (t == inj) begin
        cmd = 16'hFFFF; cpol = ~pol; cpha = ~pha; ss_sel = ~sel; wrt = 1'b1;
      end
      if (t == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_async_sclk", 32'(m_sclk), 32'd1);
        check_eq("rst_async_ssn",  32'(m_ssn),  32'h7);
        check_eq("rst_async_busy", 32'(m_busy), 32'd0);
        check_eq("rst_async_mosi", 32'(m_mosi), 32'd0);
        check_eq("rst_async_rd",   32'(m_rd),   32'd0);
      end
      if (t == rst_at + 1) rst_n = 1'b1;
    end
    wrt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; wrt = 1'b0; dsel = 0; cmd = '0; cpol = 1'b1; cpha = 1'b1;
    ss_sel = '0; loop_en = 1'b1; slave_sh = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_sclk", 32'(m_sclk), 32'd1);
    check_eq("reset_ssn",  32'(m_ssn),  32'h7);
    check_eq("reset_mosi", 32'(m_mosi), 32'd0);
    check_eq("reset_busy", 32'(m_busy), 32'd0);
    check_eq("reset_done", 32'(m_done), 32'd0);
    check_eq("reset_rd",   32'(m_rd),   32'd0);
    dsel = 1;
    #1 check_eq("reset_ssn3", 32'(m_ssn), 32'h7);
    dsel = 0;
    rst_n = 1'b1;

    // Mode 3, loopback
    run(0, 16'hA5C3, 1'b1, 1'b1, 1'b1, 16'h0, 2'd0, 0, 1'b0, 16'h0, 0, 520);
    check_eq("m3_ss_fall",  ss_fall, 1);
    check_eq("m3_first_e",  first_e, 5);
    check_eq("m3_last_e",   last_e,  501);
    check_eq("m3_done_cyc", done1,   505);
    check_eq("m3_done_n",   done_n,  1);
    check_eq("m3_rd",       32'(rd1),    32'hA5C3);
    check_eq("m3_rises",    rises,   16);
    check_eq("m3_busy_n",   busy_n,  504);
    check_eq("m3_mosi",     32'(mosi_w), 32'hA5C3);
    check_eq("m3_ss_acc",   32'(ss_acc), 32'h6);

    // Mode 0, slave returns 1234, ignored wrt with FFFF at cycle 200
    run(0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h1234, 2'd0, 200, 1'b0, 16'h0, 0, 600);
    check_eq("m0_sclk_idle", 32'(sclk_t1), 32'd0);
    check_eq("m0_mosi_pre",  32'(mosi_t4), 32'd0);
    check_eq("m0_done_n",    done_n, 1);
    check_eq("m0_done_cyc",  done1,  505);
    check_eq("m0_mosi",      32'(mosi_w), 32'h0F0F);
    check_eq("m0_rd",        32'(rd1),    32'h1234);
    check_eq("m0_rises",     rises,  16);

    // Back-to-back: wrt on the done cycle
    run(0, 16'h5A5A, 1'b1, 1'b1, 1'b1, 16'h0, 2'd0, 0, 1'b1, 16'h3C5A, 0, 1030);
    check_eq("b2b_done_n", done_n, 2);
    check_eq("b2b_done1",  done1,  505);
    check_eq("b2b_done2",  done2,  1010);
    check_eq("b2b_rd1",    32'(rd1), 32'h5A5A);
    check_eq("b2b_rd2",    32'(rd2), 32'h3C5A);
    check_eq("b2b_ss_hi",  mid_hi, 1);

    // Reset mid-transfer on the default build
    run(0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 16'h0, 2'd0, 0, 1'b0, 16'h0, 200, 600);
    check_eq("rst_no_done", done_n, 0);

    // NUM_SS=3
    run(1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0, 2'd2, 0, 1'b0, 16'h0, 0, 520);
    check_eq("ss2_fall", ss_fall, 1);
    check_eq("ss2_acc",  32'(ss_acc), 32'h3);
    check_eq("ss2_done", done1, 505);
    run(1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0, 2'd3, 0, 1'b0, 16'h0, 0, 520);
    check_eq("ss3_fall",   ss_fall, -1);
    check_eq("ss3_acc",    32'(ss_acc), 32'h7);
    check_eq("ss3_done",   done1,  505);
    check_eq("ss3_done_n", done_n, 1);

    // Small build: reset mid-transfer, then a clean mode-1 loopback transfer
    run(2, 16'h00A5, 1'b0, 1'b1, 1'b1, 16'h0, 2'd0, 0, 1'b0, 16'h0, 20, 60);
    check_eq("sm_rst_no_done", done_n, 0);
    run(2, 16'h0096, 1'b0, 1'b1, 1'b1, 16'h0, 2'd0, 0, 1'b0, 16'h0, 0, 50);
    check_eq("sm_done_cyc", done1,   35);
    check_eq("sm_rd",       32'(rd1), 32'h0096);
    check_eq("sm_rises",    rises,   8);
    check_eq("sm_first_e",  first_e, 3);
    check_eq("sm_last_e",   last_e,  33);
    check_eq("sm_mosi",     32'(mosi_w), 32'h0096);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
